mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one 32-bit memory port between two requesters: port A (instruction fetch) and port B (data load/store).
- Sequences each access as a req/ack transaction and picks a winner round-robin when both request at once.
- Drives the select of two mux2x1_32 instances, one for address and one for write data, plus write-enable routing.
- Sits between the fetch/LSU logic and the shared memory model in the MIPS core.

Parameters:
- TIMEOUT, 16, cycles a granted access may wait for mem_ack before it is aborted; 0 disables the timeout.
- CW, 5, width of the wait counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req_a  in  1  port A request; held until ack_a
- addr_a  in  32  port A address
- wdata_a  in  32  port A write data
- we_a  in  1  port A write enable
- req_b  in  1  port B request; held until ack_b
- addr_b  in  32  port B address
- wdata_b  in  32  port B write data
- we_b  in  1  port B write enable
- gnt_a  out  1  A owns the port
- gnt_b  out  1  B owns the port
- ack_a  out  1  A transaction complete, one cycle
- ack_b  out  1  B transaction complete, one cycle
- err  out  1  current ack is a timeout abort, one cycle
- err_flag  out  1  sticky timeout indicator, cleared only by rst
- rdata  out  32  mem_rdata passthrough to both ports
- sel  out  1  mux select: 0 = A, 1 = B
- mem_req  out  1  memory access valid
- mem_addr  out  32  muxed address
- mem_wdata  out  32  muxed write data
- mem_we  out  1  muxed write enable
- mem_ack  in  1  memory completion
- mem_rdata  in  32  memory read data

Behaviour:
- States: IDLE, BUSY_A, BUSY_B. Registers: state, sel, last (last winner), wait_cnt, err_flag.
- Reset (async, immediate): state=IDLE, sel=0, last=1 (so A wins first), wait_cnt=0, err_flag=0.
  - While in reset: gnt_a, gnt_b, ack_a, ack_b, err, mem_req, mem_we are all 0.
  - Reset asserted mid-transaction drops mem_req at once; no ack is issued.
- Decoded outputs:
  - gnt_a = (state==BUSY_A); gnt_b = (state==BUSY_B); mem_req = gnt_a | gnt_b.
  - mem_addr and mem_wdata come from the mux2x1_32 instances on sel. mem_we = mem_req & (sel ? we_b : we_a).
  - rdata = mem_rdata at all times.
- IDLE:
  - req_a only -> BUSY_A, sel=0. req_b only -> BUSY_B, sel=1.
  - Both -> grant the port that is not `last`.
  - Latency: req seen at edge N gives gnt high from edge N+1.
- BUSY_x, completion: ack_x = gnt_x & mem_ack (combinational). On that edge:
  - last=x, wait_cnt=0.
  - If the other port's req is high, go directly to BUSY_other with sel flipped (zero idle cycles).
  - Otherwise go to IDLE.
  - x's own req is ignored during its ack cycle.
- BUSY_x, waiting: wait_cnt increments every cycle without mem_ack.
- BUSY_x, timeout: when TIMEOUT≠0 and wait_cnt==TIMEOUT with no mem_ack:
  - ack_x=1 and err=1 for that cycle; err_flag sets.
  - The transaction ends exactly as a normal ack (same next-state rules).
  - mem_ack and timeout in the same cycle count as a normal ack, err=0.
- BUSY_x, request withdrawn: req_x low without ack is a protocol violation. Next edge goes to IDLE, no ack is issued, last is unchanged, wait_cnt=0.
- Consecutive requests from one port with the other idle: IDLE sits between them, so the turnaround is one dead cycle.
- sel is held stable throughout BUSY and only changes on a grant transition.

Decomposition:
- Shared package (mips_defs): state encodings ST_IDLE=2'd0, ST_BUSY_A=2'd1, ST_BUSY_B=2'd2; SEL_A=1'b0, SEL_B=1'b1.
- Sub-module: the existing mux2x1_32, instantiated twice (address, write data).
- FSM, counter and round-robin logic stay in this module.

Test Plan:
- Reset: rst=1 mid BUSY_A -> mem_req and gnt_a drop to 0 the same cycle. After release: sel=0, err_flag=0.
- Single access: req_a=1, addr_a=0x0000_0040; mem_ack 3 cycles after gnt_a -> mem_addr=0x40 while granted. ack_a pulses once, rdata equals mem_rdata=0xDEAD_BEEF, then return to IDLE.
- Simultaneous requests after reset: req_a=req_b=1 -> A granted first. On ack_a the block goes directly to BUSY_B (sel=1, mem_addr=addr_b) with no idle cycle, then A wins the next tie.
- Write routing: B granted with we_b=1, wdata_b=0x1234_5678, we_a=1 -> mem_we=1 and mem_wdata=0x1234_5678. Port A's write enable does not leak through.
- Timeout: TIMEOUT=4, no mem_ack -> ack_b=1 and err=1 on the 5th BUSY cycle (wait_cnt==4); err_flag stays 1. With req_a pending, A is granted next cycle.
- Withdrawal: gnt_a high, req_a drops -> IDLE next cycle with no ack_a and last unchanged. A following tie still goes to the port that would have won before.

Source files
------------

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared encodings for the MIPS core memory path
package mips_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_A = 2'd1,
    ST_BUSY_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2x1_32.sv
// rtl/mux2x1_32.sv - 32-bit two-input multiplexer
module mux2x1_32 (
  input  logic [31:0] d0_i,
  input  logic [31:0] d1_i,
  input  logic        sel_i,
  output logic [31:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin req/ack arbiter sharing one memory port between fetch (A) and LSU (B)
module mem_port_arbiter
  import mips_defs::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [31:0] addr_a,
  input  logic [31:0] wdata_a,
  input  logic        we_a,
  input  logic        req_b,
  input  logic [31:0] addr_b,
  input  logic [31:0] wdata_b,
  input  logic        we_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        err,
  output logic        err_flag,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  arb_state_t    state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          err_flag_q, err_flag_d;

  logic timeout_hit;
  logic done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= SEL_A;
      last_q     <= SEL_B;
      wait_q     <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      wait_q     <= wait_d;
      err_flag_q <= err_flag_d;
    end
  end

  // Gating with rst makes the port go quiet in the same cycle reset is raised.
  assign gnt_a   = (state_q == ST_BUSY_A) & ~rst;
  assign gnt_b   = (state_q == ST_BUSY_B) & ~rst;
  assign mem_req = gnt_a | gnt_b;

  assign timeout_hit = (TIMEOUT != 0) && (wait_q == TO_VAL);
  assign done        = mem_ack | timeout_hit;

  assign ack_a    = gnt_a & done;
  assign ack_b    = gnt_b & done;
  assign err      = mem_req & timeout_hit & ~mem_ack;
  assign err_flag = err_flag_q;
  assign sel      = sel_q;
  assign rdata    = mem_rdata;
  assign mem_we   = mem_req & (sel_q ? we_b : we_a);

  mux2x1_32 u_addr_mux (
    .d0_i  (addr_a),
    .d1_i  (addr_b),
    .sel_i (sel_q),
    .y_o   (mem_addr)
  );

  mux2x1_32 u_wdata_mux (
    .d0_i  (wdata_a),
    .d1_i  (wdata_b),
    .sel_i (sel_q),
    .y_o   (mem_wdata)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    wait_d     = wait_q;
    err_flag_d = err_flag_q;
    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        // On a tie the port that did not win last time goes first.
        if (req_a && (!req_b || last_q == SEL_B)) begin
          state_d = ST_BUSY_A;
          sel_d   = SEL_A;
        end else if (req_b) begin
          state_d = ST_BUSY_B;
          sel_d   = SEL_B;
        end
      end
      ST_BUSY_A: begin
        if (done) begin
          last_d = SEL_A;
          wait_d = '0;
          if (err) err_flag_d = 1'b1;
          if (req_b) begin
            state_d = ST_BUSY_B;
            sel_d   = SEL_B;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!req_a) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      ST_BUSY_B: begin
        if (done) begin
          last_d = SEL_B;
          wait_d = '0;
          if (err) err_flag_d = 1'b1;
          if (req_a) begin
            state_d = ST_BUSY_A;
            sel_d   = SEL_A;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!req_b) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, we_a, we_b, mem_ack;
  logic [31:0] addr_a, addr_b, wdata_a, wdata_b, mem_rdata;
  logic        gnt_a, gnt_b, ack_a, ack_b, err, err_flag, sel, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.TIMEOUT(4), .CW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .we_a      (we_a),
    .req_b     (req_b),
    .addr_b    (addr_b),
    .wdata_b   (wdata_b),
    .we_b      (we_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .ack_a     (ack_a),
    .ack_b     (ack_b),
    .err       (err),
    .err_flag  (err_flag),
    .rdata     (rdata),
    .sel       (sel),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({gnt_a, gnt_b, ack_a, ack_b, err, mem_req, mem_we} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000000", {gnt_a, gnt_b, ack_a, ack_b, err, mem_req, mem_we});
    end
    rst = 1'b0;
    req_a = 1'b1; addr_a = 32'h0000_0010;
    tick();
    checks++;
    if (gnt_a !== 1'b1 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_grant gnt_a=%b mem_req=%b want 1 1", gnt_a, mem_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (gnt_a !== 1'b0 || mem_req !== 1'b0 || ack_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_busy gnt_a=%b mem_req=%b ack_a=%b want 0 0 0", gnt_a, mem_req, ack_a);
    end
    req_a = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (sel !== 1'b0 || err_flag !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_release sel=%b err_flag=%b mem_req=%b want 0 0 0", sel, err_flag, mem_req);
    end
  endtask

  task automatic test_single();
    int acks;
    acks = 0;
    req_a = 1'b1; addr_a = 32'h0000_0040; mem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (gnt_a !== 1'b1 || mem_addr !== 32'h0000_0040 || sel !== 1'b0) begin
      failures++;
      $display("FAIL single_grant gnt_a=%b mem_addr=%h sel=%b want 1 00000040 0", gnt_a, mem_addr, sel);
    end
    for (int i = 0; i < 3; i++) begin
      if (ack_a === 1'b1) acks++;
      tick();
    end
    mem_ack = 1'b1;
    #1;
    if (ack_a === 1'b1) acks++;
    checks++;
    if (acks != 1 || rdata !== 32'hDEAD_BEEF || err !== 1'b0) begin
      failures++;
      $display("FAIL single_ack acks=%0d rdata=%h err=%b want 1 deadbeef 0", acks, rdata, err);
    end
    tick();
    mem_ack = 1'b0; req_a = 1'b0;
    #1;
    checks++;
    if (gnt_a !== 1'b0 || ack_a !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL single_idle gnt_a=%b ack_a=%b mem_req=%b want 0 0 0", gnt_a, ack_a, mem_req);
    end
  endtask

  task automatic test_tie();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a = 1'b1; req_b = 1'b1; addr_a = 32'h0000_0100; addr_b = 32'h0000_0200;
    tick();
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || mem_addr !== 32'h0000_0100) begin
      failures++;
      $display("FAIL tie_first gnt_a=%b gnt_b=%b mem_addr=%h want 1 0 00000100", gnt_a, gnt_b, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    req_a = 1'b0; mem_ack = 1'b0;
    #1;
    checks++;
    if (gnt_b !== 1'b1 || sel !== 1'b1 || mem_addr !== 32'h0000_0200) begin
      failures++;
      $display("FAIL tie_handoff gnt_b=%b sel=%b mem_addr=%h want 1 1 00000200", gnt_b, sel, mem_addr);
    end
    mem_ack = 1'b1;
    #1;
    checks++;
    if (ack_b !== 1'b1 || ack_a !== 1'b0) begin
      failures++;
      $display("FAIL tie_ack_b ack_b=%b ack_a=%b want 1 0", ack_b, ack_a);
    end
    tick();
    mem_ack = 1'b0; req_b = 1'b0;
    #1;
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      failures++;
      $display("FAIL tie_idle gnt_a=%b gnt_b=%b want 0 0", gnt_a, gnt_b);
    end
    req_a = 1'b1; req_b = 1'b1;
    tick();
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      failures++;
      $display("FAIL tie_second gnt_a=%b gnt_b=%b want 1 0", gnt_a, gnt_b);
    end
    mem_ack = 1'b1;
    tick();
    req_a = 1'b0;
    tick();
    req_b = 1'b0; mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_write();
    req_b = 1'b1; we_b = 1'b1; wdata_b = 32'h1234_5678;
    we_a = 1'b1; wdata_a = 32'hAAAA_5555;
    tick();
    checks++;
    if (gnt_b !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL write_b gnt_b=%b mem_we=%b mem_wdata=%h want 1 1 12345678", gnt_b, mem_we, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    req_b = 1'b0; mem_ack = 1'b0;
    tick();
    req_a = 1'b1; we_a = 1'b0; we_b = 1'b1;
    tick();
    checks++;
    if (gnt_a !== 1'b1 || mem_we !== 1'b0 || mem_wdata !== 32'hAAAA_5555) begin
      failures++;
      $display("FAIL write_no_leak gnt_a=%b mem_we=%b mem_wdata=%h want 1 0 aaaa5555", gnt_a, mem_we, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    req_a = 1'b0; mem_ack = 1'b0; we_b = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    req_b = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (ack_b === 1'b1 || err === 1'b1) early++;
      tick();
    end
    req_a = 1'b1;
    #1;
    checks++;
    if (early != 0 || ack_b !== 1'b1 || err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_fire early=%0d ack_b=%b err=%b want 0 1 1", early, ack_b, err);
    end
    tick();
    req_b = 1'b0;
    #1;
    checks++;
    if (gnt_a !== 1'b1 || err_flag !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_next gnt_a=%b err_flag=%b err=%b want 1 1 0", gnt_a, err_flag, err);
    end
    for (int i = 0; i < 4; i++) tick();
    mem_ack = 1'b1;
    #1;
    checks++;
    if (ack_a !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_ack_wins ack_a=%b err=%b want 1 0", ack_a, err);
    end
    tick();
    req_a = 1'b0; mem_ack = 1'b0;
    tick();
    checks++;
    if (err_flag !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky err_flag=%b want 1", err_flag);
    end
  endtask

  task automatic test_withdraw();
    req_b = 1'b1;
    tick();
    mem_ack = 1'b1;
    tick();
    req_b = 1'b0; mem_ack = 1'b0;
    tick();
    req_a = 1'b1;
    tick();
    checks++;
    if (gnt_a !== 1'b1) begin
      failures++;
      $display("FAIL withdraw_grant gnt_a=%b want 1", gnt_a);
    end
    req_a = 1'b0;
    #1;
    checks++;
    if (ack_a !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_no_ack ack_a=%b want 0", ack_a);
    end
    tick();
    checks++;
    if (gnt_a !== 1'b0 || mem_req !== 1'b0 || ack_a !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_idle gnt_a=%b mem_req=%b ack_a=%b want 0 0 0", gnt_a, mem_req, ack_a);
    end
    req_a = 1'b1; req_b = 1'b1;
    tick();
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_last gnt_a=%b gnt_b=%b want 1 0", gnt_a, gnt_b);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0; mem_ack = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0; mem_rdata = '0;
    test_reset();
    test_single();
    test_tie();
    test_write();
    test_timeout();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
